// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encodings, default bus widths, response payload
// and the GPIO peripheral register map.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 6;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  // GPIO register offsets, common to the slave, the bridge users and benches
  localparam logic [APB_ADDR_W-1:0] GPIO_ID        = 6'h00;
  localparam logic [APB_ADDR_W-1:0] GPIO_DIR       = 6'h04;
  localparam logic [APB_ADDR_W-1:0] GPIO_OUT       = 6'h08;
  localparam logic [APB_ADDR_W-1:0] GPIO_IN        = 6'h0C;
  localparam logic [APB_ADDR_W-1:0] GPIO_SET       = 6'h10;
  localparam logic [APB_ADDR_W-1:0] GPIO_CLR       = 6'h14;
  localparam logic [APB_ADDR_W-1:0] GPIO_TGL       = 6'h18;
  localparam logic [APB_ADDR_W-1:0] GPIO_IRQ_EN    = 6'h1C;
  localparam logic [APB_ADDR_W-1:0] GPIO_IRQ_STAT  = 6'h20;
  localparam logic [APB_ADDR_W-1:0] GPIO_IRQ_TYPE  = 6'h24;
  localparam logic [APB_ADDR_W-1:0] GPIO_IRQ_POL   = 6'h28;
  localparam logic [APB_ADDR_W-1:0] GPIO_IRQ_BOTH  = 6'h2C;
  localparam logic [APB_ADDR_W-1:0] GPIO_DEBOUNCE  = 6'h30;
  localparam logic [APB_ADDR_W-1:0] GPIO_PULL      = 6'h34;
  localparam logic [APB_ADDR_W-1:0] GPIO_LOCK      = 6'h38;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command, response and APB signal bundle for apb_master_bridge.
// master = bridge view, slave = requester/peripheral view.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = APB_ADDR_W,
  parameter int unsigned DATA_W = APB_DATA_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS-phase wait counter; expired_c flags the last permitted
// wait cycle. Disabled entirely when TIMEOUT_CYC is 0.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expired_c = 1'b0;
    end else begin : g_timeout
      assign expired_c = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 requester: converts a valid/ready command stream into single APB
// transfers and returns data, PSLVERR and a bus-hang timeout as a response.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_bridge_if.master  bus
);

  apb_state_e state_q, state_d;

  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;

  logic timer_clr;
  logic timer_en;
  logic timer_expired_c;

  apb_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst       (PRESET),
    .clr       (timer_clr),
    .en        (timer_en),
    .expired_c (timer_expired_c)
  );

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.cmd_valid) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (bus.PREADY || timer_expired_c) state_d = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values; PREADY wins over a same-cycle timeout
  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        timer_clr = 1'b1;
      end
      ST_ACCESS: begin
        if (bus.PREADY) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
        end else begin
          timer_en = 1'b1;
          if (timer_expired_c) begin
            psel_d        = 1'b0;
            penable_d     = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Bus and response registers
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = (state_q == ST_IDLE) & ~PRESET;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a response scoreboard queue.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic clk;
  logic rst;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  apb_rsp_t sb_q[$];

  apb_master_bridge_if #(.ADDR_W(6), .DATA_W(32)) bus ();

  apb_master_bridge #(
    .ADDR_W      (6),
    .DATA_W      (32),
    .TIMEOUT_CYC (8)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic apb_rsp_t mk_rsp(input logic [31:0] d, input logic e, input logic t);
    apb_rsp_t r;
    r.rdata   = d;
    r.err     = e;
    r.timeout = t;
    return r;
  endfunction

  // Present a command at a negedge; it is accepted on the following posedge.
  task automatic issue(input logic w, input logic [5:0] a, input logic [31:0] d,
                       input apb_rsp_t exp, input bit push);
    chk("cmd_ready_before_issue", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    if (push) sb_q.push_back(exp);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare against the scoreboard, handshake it.
  task automatic get_rsp(input string tag);
    apb_rsp_t exp;
    int waited = 0;
    while (!bus.rsp_valid && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, "_rdata"},   64'(bus.rsp_rdata),   64'(exp.rdata));
      chk({tag, "_err"},     64'(bus.rsp_err),     64'(exp.err));
      chk({tag, "_timeout"}, 64'(bus.rsp_timeout), 64'(exp.timeout));
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_cleared"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    int pen_cnt;
    apb_rsp_t held;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b1;
    bus.PSLVERR   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_psel",      64'(bus.PSEL),        64'd0);
    chk("rst_penable",   64'(bus.PENABLE),     64'd0);
    chk("rst_pwrite",    64'(bus.PWRITE),      64'd0);
    chk("rst_paddr",     64'(bus.PADDR),       64'd0);
    chk("rst_pwdata",    64'(bus.PWDATA),      64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid),   64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata),   64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err),     64'd0);
    chk("rst_rsp_to",    64'(bus.rsp_timeout), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready),   64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);

    // 1: write, no wait states, latency T+1/T+2/T+3
    issue(1'b1, GPIO_DIR, 32'hDEADBEEF, mk_rsp(32'h0, 1'b0, 1'b0), 1'b1);
    chk("t1_psel_t1",      64'(bus.PSEL),      64'd1);
    chk("t1_penable_t1",   64'(bus.PENABLE),   64'd0);
    chk("t1_cmd_ready_t1", 64'(bus.cmd_ready), 64'd0);
    chk("t1_paddr",        64'(bus.PADDR),     64'h04);
    chk("t1_pwdata",       64'(bus.PWDATA),    64'hDEADBEEF);
    chk("t1_pwrite",       64'(bus.PWRITE),    64'd1);
    @(negedge clk);
    chk("t1_penable_t2",   64'(bus.PENABLE),   64'd1);
    chk("t1_psel_t2",      64'(bus.PSEL),      64'd1);
    chk("t1_rsp_valid_t2", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    chk("t1_rsp_valid_t3", 64'(bus.rsp_valid), 64'd1);
    chk("t1_psel_t3",      64'(bus.PSEL),      64'd0);
    get_rsp("t1");
    chk("t1_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);

    // 2: read with 3 wait states
    bus.PREADY = 1'b0;
    issue(1'b0, GPIO_DIR, 32'h0, mk_rsp(32'hA5A5A5A5, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("t2_penable", 64'(bus.PENABLE), 64'd1);
      chk("t2_paddr",   64'(bus.PADDR),   64'h04);
      if (i == 3) begin
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'hA5A5A5A5;
      end
      @(negedge clk);
    end
    chk("t2_penable_drop", 64'(bus.PENABLE), 64'd0);
    bus.PRDATA = '0;
    get_rsp("t2");

    // 3: read with PSLVERR
    issue(1'b0, GPIO_OUT, 32'h0, mk_rsp(32'h12345678, 1'b1, 1'b0), 1'b1);
    bus.PSLVERR = 1'b1;
    bus.PRDATA  = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    chk("t3_psel_low", 64'(bus.PSEL), 64'd0);
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
    get_rsp("t3");

    // 4: PREADY stuck low -> timeout after 8 ACCESS cycles
    bus.PREADY = 1'b0;
    bus.PRDATA = 32'hFFFFFFFF;
    issue(1'b0, GPIO_SET, 32'h0, mk_rsp(32'h0, 1'b1, 1'b1), 1'b1);
    @(negedge clk);
    pen_cnt = 0;
    for (int i = 0; i < 20 && bus.PENABLE; i++) begin
      pen_cnt++;
      @(negedge clk);
    end
    chk("t4_access_cycles", 64'(pen_cnt), 64'd8);
    chk("t4_psel_drop", 64'(bus.PSEL), 64'd0);
    get_rsp("t4");
    bus.PREADY = 1'b1;
    bus.PRDATA = '0;

    // 5: response back-pressure with the next command already waiting
    issue(1'b1, GPIO_OUT, 32'hCAFEF00D, mk_rsp(32'h0, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    held = mk_rsp(bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = GPIO_IN;
    bus.PRDATA    = 32'h0BADF00D;
    sb_q.push_back(mk_rsp(32'h0BADF00D, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t5_hold_valid",     64'(bus.rsp_valid), 64'd1);
      chk("t5_hold_rsp",       64'({bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout}), 64'(held));
      chk("t5_hold_cmd_ready", 64'(bus.cmd_ready), 64'd0);
      chk("t5_hold_psel",      64'(bus.PSEL),      64'd0);
    end
    get_rsp("t5a");
    chk("t5_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("t5_second_psel", 64'(bus.PSEL),  64'd1);
    chk("t5_second_addr", 64'(bus.PADDR), 64'(GPIO_IN));
    get_rsp("t5b");
    bus.PRDATA = '0;

    // 6: reset during ACCESS drops the bus with no response
    bus.PREADY = 1'b0;
    issue(1'b1, GPIO_TGL, 32'h55AA55AA, mk_rsp(32'h0, 1'b0, 1'b0), 1'b0);
    @(negedge clk);
    chk("t6_in_access", 64'(bus.PENABLE), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t6_psel",      64'(bus.PSEL),      64'd0);
    chk("t6_penable",   64'(bus.PENABLE),   64'd0);
    chk("t6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t6_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    bus.PREADY = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t6_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
